// File: rtl/execute_md_stage.sv
// Execute stage: operand forwarding, single-cycle ALU, iterative
// shift-add multiplier / restoring divider, and the EX/MEM register.
module execute_md_stage #(
  parameter int XLEN  = 32,
  parameter int REGW  = 5,
  parameter int MD_EN = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ValidE,
  input  logic            FlushE,
  input  logic            RegWriteE,
  input  logic            MemtoRegE,
  input  logic            MemWriteE,
  input  logic            ALUSrcE,
  input  logic            RegDstE,
  input  logic [3:0]      ALUControlE,
  input  logic [REGW-1:0] RtE,
  input  logic [REGW-1:0] RdE,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic [XLEN-1:0] RD1E,
  input  logic [XLEN-1:0] RD2E,
  input  logic [XLEN-1:0] ResultW,
  input  logic [XLEN-1:0] SignImmE,
  output logic            BusyE,
  output logic [REGW-1:0] WriteRegE,
  output logic            ValidM,
  output logic            RegWriteM,
  output logic            MemtoRegM,
  output logic            MemWriteM,
  output logic [XLEN-1:0] ALUOutM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [REGW-1:0] WriteRegM
);

  localparam int SHW = $clog2(XLEN);

  logic [XLEN-1:0] src_a, wd_e, src_b;
  logic [XLEN-1:0] alu_res, res_e, md_res;
  logic            is_md, md_sel, md_busy, load;

  logic            valid_q, valid_d;
  logic            rw_q, rw_d;
  logic            m2r_q, m2r_d;
  logic            mw_q, mw_d;
  logic [XLEN-1:0] alu_q, alu_d;
  logic [XLEN-1:0] wd_q, wd_d;
  logic [REGW-1:0] wr_q, wr_d;

  assign WriteRegE = RegDstE ? RdE : RtE;
  assign is_md     = (ALUControlE[3:2] == 2'b10);

  always_comb begin
    case (ForwardAE)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = ALUOutM;
      default: src_a = RD1E;
    endcase
    case (ForwardBE)
      2'b01:   wd_e = ResultW;
      2'b10:   wd_e = ALUOutM;
      default: wd_e = RD2E;
    endcase
  end

  assign src_b = ALUSrcE ? SignImmE : wd_e;

  // MD opcodes fall through to ADD when the MD unit is absent
  always_comb begin
    alu_res = '0;
    case (ALUControlE)
      4'b0000: alu_res = src_a & src_b;
      4'b0001: alu_res = src_a | src_b;
      4'b0011: alu_res = src_a ^ src_b;
      4'b0100: alu_res = src_a << src_b[SHW-1:0];
      4'b0101: alu_res = src_a >> src_b[SHW-1:0];
      4'b0110: alu_res = src_a - src_b;
      4'b0111: alu_res = {{(XLEN-1){1'b0}},
                          ($signed(src_a) < $signed(src_b))};
      4'b0010, 4'b1000, 4'b1001,
      4'b1010, 4'b1011:
               alu_res = src_a + src_b;
      default: alu_res = '0;
    endcase
  end

  assign res_e = md_sel ? md_res : alu_res;
  assign BusyE = rst_n & md_busy;
  assign load  = ValidE & ~FlushE & ~BusyE;

  if (MD_EN != 0) begin : g_md
    typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
    } md_st_e;

    md_st_e          st_q, st_d;
    logic [SHW-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [1:0]      op_q, op_d;
    logic [XLEN:0]   sum, rem_sh;
    logic [XLEN-1:0] diff;
    logic            start;

    assign start  = ValidE & is_md & ~FlushE;
    assign md_sel = is_md;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) st_q <= S_IDLE;
      else        st_q <= st_d;
    end

    always_comb begin
      st_d = st_q;
      if (FlushE) begin
        st_d = S_IDLE;
      end else begin
        case (st_q)
          S_IDLE:  if (start) st_d = S_RUN;
          S_RUN:   if (cnt_q == SHW'(XLEN-1)) st_d = S_DONE;
          S_DONE:  st_d = S_IDLE;
          default: st_d = S_IDLE;
        endcase
      end
    end

    always_comb begin
      md_busy = ValidE & is_md & ~FlushE & (st_q != S_DONE);
      md_res  = op_q[0] ? hi_q : lo_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
        hi_q  <= '0;
        lo_q  <= '0;
        b_q   <= '0;
        op_q  <= '0;
      end else begin
        cnt_q <= cnt_d;
        hi_q  <= hi_d;
        lo_q  <= lo_d;
        b_q   <= b_d;
        op_q  <= op_d;
      end
    end

    // {hi,lo}: product for MUL, {remainder,quotient} for DIV
    always_comb begin
      cnt_d  = cnt_q;
      hi_d   = hi_q;
      lo_d   = lo_q;
      b_d    = b_q;
      op_d   = op_q;
      sum    = {1'b0, hi_q} +
               {1'b0, (lo_q[0] ? b_q : {XLEN{1'b0}})};
      rem_sh = {hi_q, lo_q[XLEN-1]};
      diff   = rem_sh[XLEN-1:0] - b_q;
      if (st_q == S_IDLE && start) begin
        cnt_d = '0;
        hi_d  = '0;
        lo_d  = src_a;
        b_d   = src_b;
        op_d  = ALUControlE[1:0];
      end else if (st_q == S_RUN) begin
        cnt_d = cnt_q + SHW'(1);
        if (!op_q[1]) begin
          hi_d = sum[XLEN:1];
          lo_d = {sum[0], lo_q[XLEN-1:1]};
        end else if (rem_sh >= {1'b0, b_q}) begin
          hi_d = diff;
          lo_d = {lo_q[XLEN-2:0], 1'b1};
        end else begin
          hi_d = rem_sh[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], 1'b0};
        end
      end
    end
  end else begin : g_nomd
    assign md_busy = 1'b0;
    assign md_res  = '0;
    assign md_sel  = 1'b0;
  end

  always_comb begin
    valid_d = load;
    rw_d    = load & RegWriteE;
    mw_d    = load & MemWriteE;
    m2r_d   = m2r_q;
    alu_d   = alu_q;
    wd_d    = wd_q;
    wr_d    = wr_q;
    if (load) begin
      m2r_d = MemtoRegE;
      alu_d = res_e;
      wd_d  = wd_e;
      wr_d  = WriteRegE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      rw_q    <= 1'b0;
      m2r_q   <= 1'b0;
      mw_q    <= 1'b0;
      alu_q   <= '0;
      wd_q    <= '0;
      wr_q    <= '0;
    end else begin
      valid_q <= valid_d;
      rw_q    <= rw_d;
      m2r_q   <= m2r_d;
      mw_q    <= mw_d;
      alu_q   <= alu_d;
      wd_q    <= wd_d;
      wr_q    <= wr_d;
    end
  end

  assign ValidM     = valid_q;
  assign RegWriteM  = rw_q;
  assign MemtoRegM  = m2r_q;
  assign MemWriteM  = mw_q;
  assign ALUOutM    = alu_q;
  assign WriteDataM = wd_q;
  assign WriteRegM  = wr_q;

endmodule

// File: tb/tb_execute_md_stage.sv
// Scoreboard bench for execute_md_stage: directed scenarios plus
// random traffic checked against an arithmetic reference model.
module tb_execute_md_stage;

  localparam int XLEN = 32;
  localparam int REGW = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            ValidE, FlushE;
  logic            RegWriteE, MemtoRegE, MemWriteE;
  logic            ALUSrcE, RegDstE;
  logic [3:0]      ALUControlE;
  logic [REGW-1:0] RtE, RdE;
  logic [1:0]      ForwardAE, ForwardBE;
  logic [XLEN-1:0] RD1E, RD2E, ResultW, SignImmE;
  logic            BusyE;
  logic [REGW-1:0] WriteRegE;
  logic            ValidM, RegWriteM, MemtoRegM, MemWriteM;
  logic [XLEN-1:0] ALUOutM, WriteDataM;
  logic [REGW-1:0] WriteRegM;

  execute_md_stage #(
    .XLEN (XLEN),
    .REGW (REGW),
    .MD_EN(1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ValidE     (ValidE),
    .FlushE     (FlushE),
    .RegWriteE  (RegWriteE),
    .MemtoRegE  (MemtoRegE),
    .MemWriteE  (MemWriteE),
    .ALUSrcE    (ALUSrcE),
    .RegDstE    (RegDstE),
    .ALUControlE(ALUControlE),
    .RtE        (RtE),
    .RdE        (RdE),
    .ForwardAE  (ForwardAE),
    .ForwardBE  (ForwardBE),
    .RD1E       (RD1E),
    .RD2E       (RD2E),
    .ResultW    (ResultW),
    .SignImmE   (SignImmE),
    .BusyE      (BusyE),
    .WriteRegE  (WriteRegE),
    .ValidM     (ValidM),
    .RegWriteM  (RegWriteM),
    .MemtoRegM  (MemtoRegM),
    .MemWriteM  (MemWriteM),
    .ALUOutM    (ALUOutM),
    .WriteDataM (WriteDataM),
    .WriteRegM  (WriteRegM)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  wr;
    logic        rw, m2r, mw;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] rd1, rd2, imm, rw_v;
    logic [1:0]  fa, fb;
    logic        alusrc, regdst, rw, m2r, mw;
    logic [4:0]  rt, rd;
  } ins_t;

  exp_t        sb[$];
  exp_t        me;
  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] exp_aluout;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  function automatic logic [31:0] fsel(input logic [1:0] s,
      input logic [31:0] base, input logic [31:0] rw,
      input logic [31:0] ao);
    if (s == 2'd1) return rw;
    if (s == 2'd2) return ao;
    return base;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] op,
      input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    int          sh;
    p  = 64'(a) * 64'(b);
    sh = int'(b % 32);
    case (op)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd3:    return a ^ b;
      4'd4:    return a << sh;
      4'd5:    return a >> sh;
      4'd6:    return a - b;
      4'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd8:    return p[31:0];
      4'd9:    return p[63:32];
      4'd10:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd11:   return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic ins_t mk(input logic [3:0] op,
      input logic [31:0] rd1, input logic [31:0] rd2,
      input logic [31:0] imm, input logic [1:0] fa,
      input logic [1:0] fb, input logic alusrc);
    ins_t t;
    t.op     = op;
    t.rd1    = rd1;
    t.rd2    = rd2;
    t.imm    = imm;
    t.fa     = fa;
    t.fb     = fb;
    t.alusrc = alusrc;
    t.rw_v   = $urandom;
    t.regdst = 1'($urandom_range(0, 1));
    t.rw     = 1'($urandom_range(0, 1));
    t.m2r    = 1'($urandom_range(0, 1));
    t.mw     = 1'($urandom_range(0, 1));
    t.rt     = 5'($urandom_range(0, 31));
    t.rd     = 5'($urandom_range(0, 31));
    return t;
  endfunction

  task automatic drive(input ins_t t);
    ValidE      = 1'b1;
    ALUControlE = t.op;
    RD1E        = t.rd1;
    RD2E        = t.rd2;
    SignImmE    = t.imm;
    ResultW     = t.rw_v;
    ForwardAE   = t.fa;
    ForwardBE   = t.fb;
    ALUSrcE     = t.alusrc;
    RegDstE     = t.regdst;
    RegWriteE   = t.rw;
    MemtoRegE   = t.m2r;
    MemWriteE   = t.mw;
    RtE         = t.rt;
    RdE         = t.rd;
  endtask

  // Called just after a rising edge; returns just after the load edge
  task automatic issue(input ins_t t);
    exp_t        e;
    logic [31:0] a, wd, b;
    int          busy;
    logic        bad;
    logic        md;
    a     = fsel(t.fa, t.rd1, t.rw_v, exp_aluout);
    wd    = fsel(t.fb, t.rd2, t.rw_v, exp_aluout);
    b     = t.alusrc ? t.imm : wd;
    e.alu = ref_alu(t.op, a, b);
    e.wd  = wd;
    e.wr  = t.regdst ? t.rd : t.rt;
    e.rw  = t.rw;
    e.m2r = t.m2r;
    e.mw  = t.mw;
    md    = (t.op[3:2] == 2'b10);
    sb.push_back(e);
    drive(t);
    busy = 0;
    bad  = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!BusyE) break;
      busy++;
      if (busy > 1 && ValidM) bad = 1'b1;
    end
    check("write_reg_e", 64'(WriteRegE), 64'(e.wr));
    check("busy_len", 64'(busy), md ? 64'(XLEN + 1) : 64'd0);
    if (md) check("md_bubble", 64'(bad), 64'd0);
    @(posedge clk);
    #1;
    ValidE     = 1'b0;
    exp_aluout = e.alu;
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && ValidM === 1'b1) begin
      if (sb.size() == 0) begin
        check("m_unexpected", 64'(ValidM), 64'd0);
      end else begin
        me = sb.pop_front();
        check("alu_out_m", 64'(ALUOutM), 64'(me.alu));
        check("write_data_m", 64'(WriteDataM), 64'(me.wd));
        check("m_ctl", 64'({WriteRegM, RegWriteM, MemtoRegM, MemWriteM}),
              64'({me.wr, me.rw, me.m2r, me.mw}));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    ins_t        t;
    logic [3:0]  op;
    logic [31:0] rb;
    rst_n  = 1'b1;
    FlushE = 1'b0;
    drive(mk(4'd8, 32'h1234, 32'h55, 32'd0, 2'd0, 2'd0, 1'b0));
    #1 rst_n = 1'b0;
    #2;
    check("rst_busy", 64'(BusyE), 64'd0);
    check("rst_m", 64'({ValidM, RegWriteM, MemtoRegM, MemWriteM,
                        ALUOutM, WriteDataM, WriteRegM}), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    ValidE = 1'b0;
    rst_n  = 1'b1;
    exp_aluout = '0;
    @(posedge clk);
    #1;

    issue(mk(4'd2, 32'hFFFF_FFFF, 32'd1, 32'd0, 2'd0, 2'd0, 1'b0));
    issue(mk(4'd2, 32'd8, 32'd8, 32'd0, 2'd0, 2'd0, 1'b0));
    issue(mk(4'd6, $urandom, 32'd5, 32'd3, 2'd2, 2'd0, 1'b1));
    t = mk(4'd6, $urandom, 32'd5, 32'd3, 2'd1, 2'd0, 1'b1);
    t.rw_v = 32'd7;
    issue(t);
    issue(mk(4'd8, 32'h0000_FFFF, 32'h0001_0001, 32'd0, 2'd0, 2'd0, 1'b0));
    issue(mk(4'd9, 32'h0000_FFFF, 32'h0001_0001, 32'd0, 2'd0, 2'd0, 1'b0));
    issue(mk(4'd10, 32'd100, 32'd0, 32'd0, 2'd0, 2'd0, 1'b0));
    issue(mk(4'd11, 32'd100, 32'd0, 32'd0, 2'd0, 2'd0, 1'b0));
    issue(mk(4'd10, 32'd100, 32'd7, 32'd0, 2'd0, 2'd0, 1'b0));
    issue(mk(4'd11, 32'd100, 32'd7, 32'd0, 2'd0, 2'd0, 1'b0));

    drive(mk(4'd8, 32'h00AB_CDEF, 32'h77, 32'd0, 2'd0, 2'd0, 1'b0));
    repeat (5) @(posedge clk);
    #1 FlushE = 1'b1;
    @(negedge clk);
    check("flush_busy", 64'(BusyE), 64'd0);
    @(posedge clk);
    #1;
    FlushE = 1'b0;
    ValidE = 1'b0;
    @(negedge clk);
    check("flush_bubble", 64'({ValidM, RegWriteM, MemWriteM}), 64'd0);
    @(posedge clk);
    #1;
    issue(mk(4'd2, 32'd40, 32'd2, 32'd0, 2'd0, 2'd0, 1'b0));
    issue(mk(4'd8, 32'd12, 32'd11, 32'd0, 2'd0, 2'd0, 1'b0));

    drive(mk(4'd10, 32'd9999, 32'd13, 32'd0, 2'd0, 2'd0, 1'b0));
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(BusyE), 64'd0);
    check("midrst_m", 64'({ValidM, RegWriteM, MemtoRegM, MemWriteM,
                           ALUOutM, WriteDataM, WriteRegM}), 64'd0);
    @(negedge clk);
    ValidE = 1'b0;
    rst_n  = 1'b1;
    exp_aluout = '0;
    @(posedge clk);
    #1;
    issue(mk(4'd10, 32'd9, 32'd3, 32'd0, 2'd0, 2'd0, 1'b0));

    for (int i = 0; i < 200; i++) begin
      op = 4'($urandom_range(0, 15));
      if (op[3:2] == 2'b10 && $urandom_range(0, 2) != 0)
        op = 4'($urandom_range(0, 7));
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9))
                                       : $urandom;
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk);
        #1;
      end
      issue(mk(op, $urandom, rb, 32'($urandom_range(0, 40)),
               2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1))));
    end

    repeat (3) @(posedge clk);
    check("sb_drain", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/execute_md_stage.md
EXECUTE_MD_STAGE -- requirements
Module: execute_md_stage

Interface
REQ-001 Parameter: XLEN, 32, datapath width (8..64, even).
REQ-002 Parameter: REGW, 5, register-address width.
REQ-003 Parameter: MD_EN, 1, 1 = multiply/divide unit present; 0 = MD opcodes execute as ADD.
REQ-004 Clocking SHALL use one clock; reset is asynchronous and active-low.
REQ-005 Ports, in this order:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- ValidE  in  1  an instruction is present in E.
- FlushE  in  1  kill the E instruction.
- RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE  in  1 each  control.
- ALUControlE  in  4  operation select.
- RtE, RdE  in  REGW  destination candidates.
- ForwardAE, ForwardBE  in  2  operand-source select.
- RD1E, RD2E, ResultW, SignImmE  in  XLEN  operands.
- BusyE  out  1  stall request to F/D/E.
- WriteRegE  out  REGW  RegDstE ? RdE : RtE (combinational).
- ValidM, RegWriteM, MemtoRegM, MemWriteM  out  1  EX/MEM control.
- ALUOutM, WriteDataM  out  XLEN  EX/MEM data.
- WriteRegM  out  REGW  EX/MEM destination.

Function
REQ-006 SrcA SHALL be: RD1E for ForwardAE=00; ResultW for 01; ALUOutM (the internal register) for 10; RD1E for 11.
REQ-007 WriteDataE SHALL be selected by ForwardBE using the same encoding as REQ-006, with RD2E as the base operand.
REQ-008 SrcB SHALL be SignImmE when ALUSrcE=1, else WriteDataE.
REQ-009 ALUControlE encoding SHALL be:
- 0000 AND, 0001 OR, 0010 ADD, 0011 XOR.
- 0100 SLL, 0101 SRL: shift by SrcB[log2(XLEN)-1:0].
- 0110 SUB.
- 0111 SLT: signed, result 0 or 1.
- 1000 MUL (low XLEN bits), 1001 MULHU (high XLEN bits, unsigned), 1010 DIVU, 1011 REMU.
- 11xx: result 0.
REQ-010 ADD and SUB SHALL wrap modulo 2^XLEN; no flags are produced.
REQ-011 Opcodes 1000-1011 are MD ops; all other opcodes are single-cycle.
REQ-012 The MD FSM SHALL have states IDLE, RUN and DONE, plus an iteration counter of width clog2(XLEN).
REQ-013 In IDLE with ValidE=1, an MD op and FlushE=0, the block SHALL capture SrcA, SrcB and the opcode, clear the counter and go to RUN.
REQ-014 RUN SHALL perform one shift-add (MUL) or restoring-subtract (DIV) step per cycle, and go to DONE when counter=XLEN-1; RUN therefore lasts exactly XLEN cycles.
REQ-015 In DONE, the MD result SHALL be presented as the E result, and the FSM SHALL go to IDLE at the next edge.
REQ-016 BusyE SHALL equal ValidE & MD-op & (state != DONE) & ~FlushE (combinational).
REQ-017 An MD op SHALL occupy E for exactly XLEN+2 cycles.
REQ-018 Operands SHALL be sampled only at capture; forwarding inputs have no effect during RUN.
REQ-019 DIVU with divisor 0 SHALL give quotient all-ones; REMU with divisor 0 SHALL give the dividend.
REQ-020 EX/MEM register, each edge:
- if FlushE=1 or BusyE=1 or ValidE=0, load a bubble: ValidM, RegWriteM and MemWriteM = 0, other fields don't-care but held.
- otherwise, load ValidM=1, the control bits, ALUOutM = result, WriteDataM = WriteDataE, WriteRegM = WriteRegE.
REQ-021 FlushE=1 in any state SHALL return the FSM to IDLE at the next edge; flush has priority over capture and over DONE.
REQ-022 The block SHALL require upstream to hold the E inputs stable while BusyE=1; behaviour is unspecified if they change.
REQ-023 Single-cycle ops SHALL have 1-cycle latency, E to M.
REQ-024 With MD_EN=0, BusyE SHALL be held at 0 and no FSM logic SHALL be present.

Reset
REQ-025 While rst_n=0, all M outputs and BusyE SHALL be 0, the FSM SHALL be in IDLE and the counter SHALL be 0, asynchronously.
REQ-026 Reset asserted mid-RUN SHALL abort the operation; after release, a new MD op SHALL start fresh.

Verification
REQ-027 The bench SHALL cover these scenarios:
- ADD, XLEN=32, RD1E=0xFFFFFFFF, RD2E=1, Forward=00 -> next edge ALUOutM=0, ValidM=1, BusyE=0 throughout.
- Forwarding: ALUOutM=0x10, ForwardAE=10, SUB with SrcB=3 -> ALUOutM=0x0D; same op with ForwardAE=01, ResultW=7 -> 0x04.
- MUL 0x0000FFFF*0x00010001, held valid -> BusyE high for 33 cycles, ValidM=0 during them, then ALUOutM=0xFFFFFFFF, ValidM=1; MULHU of the same operands -> 0x00000000.
- DIVU 100/0 -> ALUOutM=0xFFFFFFFF; REMU 100/0 -> 100; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- FlushE pulsed in RUN cycle 5 -> FSM IDLE next edge, BusyE=0, bubble in M; the next ADD completes in 1 cycle.
- rst_n pulsed low mid-RUN -> all outputs 0 immediately; after release, a DIVU 9/3 yields 3 after 34 cycles.
